// File: rtl/trapezoid_sequencer.sv
// Trapezoid setpoint generator: RISE/HOLD/FALL/LOW periods paced by a prescaled tick,
// with shadowed configuration, a repeat count and immediate abort.
module trapezoid_sequencer #(
    parameter int DW  = 10,
    parameter int TW  = 8,
    parameter int DIV = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [DW-1:0] cfg_amp_i,
    input  logic [TW-1:0] cfg_step_i,
    input  logic [TW-1:0] cfg_hold_i,
    input  logic [TW-1:0] cfg_low_i,
    input  logic [7:0]    cfg_cycles_i,
    output logic [DW-1:0] setpoint_o,
    output logic [1:0]    phase_o,
    output logic          busy_o,
    output logic          done_o
);
    localparam int PW = $clog2(DIV);
    localparam int MW = ((DW > TW) ? DW : TW) + 1;

    typedef enum logic [2:0] {IDLE, RISE, HOLD, FALL, LOW} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] setpoint_q, setpoint_d;
    logic [1:0]    phase_q, phase_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] seg_q, seg_d;
    logic [7:0]    cyc_q, cyc_d;
    logic [DW-1:0] amp_q, amp_d;
    logic [TW-1:0] step_q, step_d;
    logic [TW-1:0] hold_q, hold_d;
    logic [TW-1:0] low_q, low_d;
    logic [7:0]    cycles_q, cycles_d;

    logic          tick;
    logic [TW-1:0] step_eff;
    logic [MW-1:0] rise_sum;
    logic [TW:0]   seg_inc;
    logic [7:0]    cyc_inc;

    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            RISE:    return 2'b00;
            HOLD:    return 2'b01;
            FALL:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    assign tick     = (state_q != IDLE) && (presc_q == PW'(DIV - 1));
    assign step_eff = (step_q == '0) ? TW'(1) : step_q;
    // Wide sum so saturation at amp is decided before any wrap can occur
    assign rise_sum = MW'(setpoint_q) + MW'(step_eff);
    assign seg_inc  = {1'b0, seg_q} + (TW+1)'(1);
    assign cyc_inc  = cyc_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            setpoint_q <= '0;
            phase_q    <= 2'b11;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            presc_q    <= '0;
            seg_q      <= '0;
            cyc_q      <= '0;
            amp_q      <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            low_q      <= '0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            setpoint_q <= setpoint_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            presc_q    <= presc_d;
            seg_q      <= seg_d;
            cyc_q      <= cyc_d;
            amp_q      <= amp_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            low_q      <= low_d;
            cycles_q   <= cycles_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        setpoint_d = setpoint_q;
        presc_d    = presc_q;
        seg_d      = seg_q;
        cyc_d      = cyc_q;
        amp_d      = amp_q;
        step_d     = step_q;
        hold_d     = hold_q;
        low_d      = low_q;
        cycles_d   = cycles_q;
        done_d     = 1'b0;

        if (state_q != IDLE) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        // Abort outranks start, ticks and period completion
        if (abort_i) begin
            state_d    = IDLE;
            setpoint_d = '0;
            presc_d    = '0;
            seg_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        amp_d      = cfg_amp_i;
                        step_d     = cfg_step_i;
                        hold_d     = cfg_hold_i;
                        low_d      = cfg_low_i;
                        cycles_d   = cfg_cycles_i;
                        presc_d    = '0;
                        seg_d      = '0;
                        cyc_d      = '0;
                        setpoint_d = '0;
                        state_d    = RISE;
                    end
                end
                RISE: begin
                    if (tick) begin
                        if (rise_sum >= MW'(amp_q)) begin
                            setpoint_d = amp_q;
                            seg_d      = '0;
                            state_d    = HOLD;
                        end else begin
                            setpoint_d = setpoint_q + DW'(step_eff);
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        seg_d = seg_inc[TW-1:0];
                        if ((hold_q == '0) || (seg_inc == {1'b0, hold_q})) begin
                            state_d = FALL;
                        end
                    end
                end
                FALL: begin
                    if (tick) begin
                        if (MW'(step_eff) >= MW'(setpoint_q)) begin
                            setpoint_d = '0;
                            seg_d      = '0;
                            state_d    = LOW;
                        end else begin
                            setpoint_d = setpoint_q - DW'(step_eff);
                        end
                    end
                end
                LOW: begin
                    if (tick) begin
                        seg_d = seg_inc[TW-1:0];
                        if ((low_q == '0) || (seg_inc == {1'b0, low_q})) begin
                            seg_d = '0;
                            cyc_d = cyc_inc;
                            // A zero repeat count never matches, so the counter just wraps
                            if ((cycles_q != 8'd0) && (cyc_inc == cycles_q)) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = RISE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d  = (state_d != IDLE);
        phase_d = phase_of(state_d);
    end

    assign setpoint_o = setpoint_q;
    assign phase_o    = phase_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_trapezoid_sequencer.sv
// Scoreboard bench for trapezoid_sequencer: a tick-level profile model queues every expected
// output change with its clk number; a monitor pops and compares each change the DUT shows.
module tb_trapezoid_sequencer;
    localparam int DW  = 10;
    localparam int TW  = 8;
    localparam int DIV = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [DW-1:0] cfg_amp_i = '0;
    logic [TW-1:0] cfg_step_i = '0;
    logic [TW-1:0] cfg_hold_i = '0;
    logic [TW-1:0] cfg_low_i = '0;
    logic [7:0]    cfg_cycles_i = '0;
    logic [DW-1:0] setpoint_o;
    logic [1:0]    phase_o;
    logic          busy_o;
    logic          done_o;

    typedef struct {
        int cyc;
        int sp;
        int ph;
        int busy;
        int done;
    } exp_t;

    exp_t          scoreQ[$];
    int            edgeCount = 0;
    int            checks = 0;
    int            errors = 0;
    bit            monOn = 1'b0;
    logic [DW+3:0] prevTuple;

    trapezoid_sequencer #(.DW(DW), .TW(TW), .DIV(DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .cfg_amp_i    (cfg_amp_i),
        .cfg_step_i   (cfg_step_i),
        .cfg_hold_i   (cfg_hold_i),
        .cfg_low_i    (cfg_low_i),
        .cfg_cycles_i (cfg_cycles_i),
        .setpoint_o   (setpoint_o),
        .phase_o      (phase_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Every change of the output tuple is one transaction to be matched against the queue
    always @(negedge clk) begin : monitor
        logic [DW+3:0] cur;
        exp_t e;
        cur = {setpoint_o, phase_o, busy_o, done_o};
        if (!monOn) begin
            prevTuple = cur;
        end else if (cur != prevTuple) begin
            prevTuple = cur;
            checks++;
            if (scoreQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_change cyc=%0d sp=%0d ph=%0d busy=%0d done=%0d, required no change",
                         edgeCount, setpoint_o, phase_o, busy_o, done_o);
            end else begin
                e = scoreQ.pop_front();
                if (e.cyc != edgeCount || e.sp != int'(setpoint_o) || e.ph != int'(phase_o) ||
                    e.busy != int'(busy_o) || e.done != int'(done_o)) begin
                    errors++;
                    $display("[TB] FAIL event got cyc=%0d sp=%0d ph=%0d busy=%0d done=%0d required cyc=%0d sp=%0d ph=%0d busy=%0d done=%0d",
                             edgeCount, setpoint_o, phase_o, busy_o, done_o,
                             e.cyc, e.sp, e.ph, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cyc=%0d, required completion", edgeCount);
        $fatal(1, "[TB] watchdog");
    end

    task automatic pushExp(input int c, input int sp, input int ph, input int b, input int d);
        exp_t e;
        exp_t last;
        e.cyc = c; e.sp = sp; e.ph = ph; e.busy = b; e.done = d;
        if (scoreQ.size() > 0) begin
            last = scoreQ[scoreQ.size()-1];
            if (last.cyc == c) begin
                scoreQ[scoreQ.size()-1] = e;
                return;
            end
        end
        scoreQ.push_back(e);
    endtask

    // Profile model: walk the trapezoid tick by tick using min/max arithmetic on the value
    task automatic buildRun(input int base, input int amp, input int step, input int hold,
                            input int low, input int cycles, input int periodsCap,
                            output int endCyc);
        int t, v, s, nPer;
        bit moving;
        s = (step == 0) ? 1 : step;
        nPer = (cycles == 0) ? periodsCap : cycles;
        t = 0;
        pushExp(base, 0, 0, 1, 0);
        for (int p = 1; p <= nPer; p++) begin
            v = 0;
            moving = 1'b1;
            while (moving) begin
                t++;
                v = (v + s > amp) ? amp : v + s;
                moving = (v < amp);
                pushExp(base + t*DIV, v, moving ? 0 : 1, 1, 0);
            end
            t += (hold == 0) ? 1 : hold;
            pushExp(base + t*DIV, amp, 2, 1, 0);
            moving = 1'b1;
            while (moving) begin
                t++;
                v = (v > s) ? v - s : 0;
                moving = (v > 0);
                pushExp(base + t*DIV, v, moving ? 2 : 3, 1, 0);
            end
            t += (low == 0) ? 1 : low;
            if (cycles != 0 && p == cycles) begin
                pushExp(base + t*DIV, 0, 3, 0, 1);
                pushExp(base + t*DIV + 1, 0, 3, 0, 0);
            end else begin
                pushExp(base + t*DIV, 0, 0, 1, 0);
            end
        end
        endCyc = base + t*DIV;
    endtask

    task automatic truncateFrom(input int c);
        exp_t last;
        while (scoreQ.size() > 0) begin
            last = scoreQ[scoreQ.size()-1];
            if (last.cyc < c) break;
            void'(scoreQ.pop_back());
        end
        pushExp(c, 0, 3, 0, 0);
    endtask

    task automatic waitEdge(input int e);
        while (edgeCount < e) @(negedge clk);
    endtask

    // Called at a negedge; start is sampled on the next rising edge, then cfg is scrambled
    task automatic applyStimulus(input int amp, input int step, input int hold, input int low,
                                 input int cycles, input int periodsCap, output int endCyc);
        cfg_amp_i    = DW'(amp);
        cfg_step_i   = TW'(step);
        cfg_hold_i   = TW'(hold);
        cfg_low_i    = TW'(low);
        cfg_cycles_i = 8'(cycles);
        start_i      = 1'b1;
        buildRun(edgeCount + 1, amp, step, hold, low, cycles, periodsCap, endCyc);
        @(negedge clk);
        start_i      = 1'b0;
        cfg_amp_i    = DW'($urandom);
        cfg_step_i   = TW'($urandom);
        cfg_hold_i   = TW'($urandom);
        cfg_low_i    = TW'($urandom);
        cfg_cycles_i = 8'($urandom);
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s got %0d required %0d", name, actual, required);
        end
    endtask

    task automatic abortAt(input int e);
        waitEdge(e - 1);
        abort_i = 1'b1;
        truncateFrom(e);
        waitEdge(e);
        abort_i = 1'b0;
    endtask

    task automatic drain(input string name);
        exp_t last;
        int budget;
        budget = 50;
        if (scoreQ.size() > 0) begin
            last = scoreQ[scoreQ.size()-1];
            budget = last.cyc - edgeCount + 50;
        end
        while (scoreQ.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (scoreQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout pending=%0d required 0", name, scoreQ.size());
            scoreQ.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int endC, e2, b;
        int offs[4];
        offs = '{13, 57, 150, 250};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        monOn = 1'b1;
        checkOutput("reset_setpoint", int'(setpoint_o), 0);
        checkOutput("reset_phase", int'(phase_o), 3);
        checkOutput("reset_busy", int'(busy_o), 0);
        checkOutput("reset_done", int'(done_o), 0);

        $display("[TB] single slow trapezoid");
        applyStimulus(20, 1, 20, 20, 1, 0, endC);
        drain("slow_run");
        checkOutput("slow_run_busy_after", int'(busy_o), 0);

        $display("[TB] saturating ramps");
        applyStimulus(25, 10, 2, 2, 1, 0, endC);
        drain("sat25");
        applyStimulus(1020, 200, 1, 1, 1, 0, endC);
        drain("sat1020");

        $display("[TB] three back-to-back periods, restart right after done");
        applyStimulus(7, 3, 0, 0, 3, 0, endC);
        waitEdge(endC);
        checkOutput("cycles3_done", int'(done_o), 1);
        applyStimulus(5, 5, 1, 1, 1, 0, e2);
        drain("cycles3");

        $display("[TB] abort during FALL, restart one clk later");
        b = edgeCount + 1;
        applyStimulus(30, 2, 3, 3, 0, 3, endC);
        abortAt(b + 20*DIV + 3);
        checkOutput("abort_setpoint", int'(setpoint_o), 0);
        checkOutput("abort_phase", int'(phase_o), 3);
        checkOutput("abort_busy", int'(busy_o), 0);
        applyStimulus(4, 2, 1, 1, 1, 0, endC);
        drain("abort_restart");

        $display("[TB] start and cfg noise while busy");
        b = edgeCount + 1;
        applyStimulus(12, 4, 4, 4, 2, 0, endC);
        foreach (offs[i]) begin
            waitEdge(b + offs[i]);
            start_i   = 1'b1;
            cfg_amp_i = DW'($urandom);
            @(negedge clk);
            start_i   = 1'b0;
        end
        drain("busy_noise");
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("start_abort_busy", int'(busy_o), 0);
        checkOutput("start_abort_phase", int'(phase_o), 3);

        $display("[TB] reset during HOLD");
        b = edgeCount + 1;
        applyStimulus(5, 5, 20, 2, 1, 0, endC);
        waitEdge(b + 50);
        #1;
        rst_n = 1'b0;
        truncateFrom(b + 51);
        #1;
        checkOutput("async_rst_setpoint", int'(setpoint_o), 0);
        checkOutput("async_rst_phase", int'(phase_o), 3);
        checkOutput("async_rst_busy", int'(busy_o), 0);
        checkOutput("async_rst_done", int'(done_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        drain("reset_hold");
        checkOutput("post_rst_busy", int'(busy_o), 0);
        checkOutput("post_rst_setpoint", int'(setpoint_o), 0);

        $display("[TB] endless run past cycle counter wrap");
        b = edgeCount + 1;
        applyStimulus(0, 0, 0, 0, 0, 260, endC);
        abortAt(b + 258*4*DIV + 5);
        drain("wrap");

        $display("[TB] randomized profiles");
        for (int r = 0; r < 6; r++) begin
            applyStimulus(int'($urandom_range(0, 40)), int'($urandom_range(0, 12)),
                          int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                          int'($urandom_range(1, 3)), 0, endC);
            drain("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
